inst_prefetch_queue: RTL and testbench
======================================

Name: inst_prefetch_queue

Overview:
- Parametrised successor to the single-entry fetch stage. It keeps a FIFO of up to FIFO_DEPTH prefetched {pc, instruction} pairs ahead of decode.
- Issues at most one outstanding word read to the instruction memory controller. Flushes and redirects on jump.
- Sits between the memory controller's instruction port and decode.
- Decode consumes through a valid/ready handshake instead of a single next_en pulse.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- FIFO_DEPTH, 4, queue entries; power of two, 2..16.
- BOOT_PC, 32'h0000_0000, fetch PC loaded at reset.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- jmp_en  in  1  redirect request.
- jmp_pc  in  ADDR_WIDTH  redirect target; bits [1:0] are ignored (forced to 0).
- inst_ready  in  1  decode accepts the head entry.
- inst_valid  out  1  head entry is valid.
- inst_code  out  32  head instruction.
- inst_addr  out  ADDR_WIDTH  head PC.
- mem_read_en  out  1  read request; held until mem_ready.
- mem_addr  out  ADDR_WIDTH  word address; stable while mem_read_en=1.
- mem_rdata  in  32  read data; valid when mem_ready=1.
- mem_ready  in  1  one-cycle response strobe.
- fetch_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0 at posedge):
  - FIFO emptied; count=0, rd/wr pointers=0.
  - fetch_pc=BOOT_PC; state=IDLE.
  - Outputs: mem_read_en=0, mem_addr=BOOT_PC, inst_valid=0, inst_code=0, inst_addr=0, fetch_busy=0.
  - Reset mid-request: any later mem_ready is ignored unless the FSM is in REQ or DISCARD.
- Credit rule:
  - Issue a request only if count + (state!=IDLE) < FIFO_DEPTH.
  - An accepted response is therefore never dropped for lack of space.
- FSM states: IDLE, REQ, DISCARD.
  - IDLE -> REQ when credit is available and jmp_en=0. In the next cycle mem_read_en=1 and mem_addr=fetch_pc (registered outputs).
  - REQ with mem_ready=1 and jmp_en=0:
    - push {fetch_pc, mem_rdata};
    - fetch_pc += 4, wrapping modulo 2^ADDR_WIDTH;
    - go to IDLE; mem_read_en=0 next cycle.
  - REQ with jmp_en=1 and mem_ready=0 -> DISCARD; mem_read_en stays 1 with the old address until the response arrives.
  - REQ with jmp_en=1 and mem_ready=1 -> data dropped; go to IDLE.
  - DISCARD with mem_ready=1 -> IDLE; data dropped, no push.
- Sustained throughput: one word every 2 cycles with zero-wait memory (REQ, response, IDLE).
- Redirect (jmp_en=1, any state):
  - FIFO cleared and fetch_pc = {jmp_pc[ADDR_WIDTH-1:2],2'b00}.
  - inst_valid=0 in the next cycle.
  - A pop or push in the same cycle is cancelled; flush wins.
  - Back-to-back jmp_en: the last target wins.
- Pop:
  - Occurs when inst_valid && inst_ready && !jmp_en.
  - Head outputs come combinationally from the FIFO head.
  - inst_code/inst_addr hold their value while inst_valid=1 and inst_ready=0.
- Push and pop in the same cycle: count unchanged; pointers each advance and wrap at FIFO_DEPTH.
- Empty: inst_valid=0; inst_ready is ignored.
- Full: no new request issues; existing entries are held.
- Latency: from reset release (or redirect with no stale response), first mem_read_en at cycle +1. The entry is valid the cycle after mem_ready.

Optional Feature:
- Macro: INST_PREFETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0], incremented per push.
  - Adds perf_flush_cnt[31:0], incremented per jmp_en cycle.
  - Adds perf_stall_cnt[31:0], incremented per cycle where inst_valid=0 and state!=DISCARD.
  - All three reset to 0 and wrap at 2^32.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset with BOOT_PC=0, zero-wait memory returning rdata=addr^32'hA5A5_0000, inst_ready=0 -> requests to 0x0,0x4,0x8,0xC, then mem_read_en stays 0. Queue full with inst_valid=1, inst_addr=0x0, inst_code=0xA5A5_0000.
- Full queue, hold inst_ready=1 for 8 cycles -> heads pop in order 0x0,0x4,0x8,0xC,0x10. No entry is duplicated or skipped; count never exceeds 4.
- Memory with 3-cycle latency; jmp_en with jmp_pc=0x103 one cycle after mem_read_en -> DISCARD. The stale response at addr 0x0 is not pushed. The next request is mem_addr=0x100 and the first head is inst_addr=0x100.
- jmp_en in the same cycle as mem_ready and inst_ready with 2 entries queued -> nothing pushed or popped. inst_valid=0 next cycle; the next request goes to the jump target.
- BOOT_PC=32'hFFFF_FFFC -> second request address is 0x0000_0000 (wrap).
- With INST_PREFETCH_PERF_EN: 4 pushes and 2 jmp_en pulses -> perf_fetch_cnt=4 and perf_flush_cnt=2. Reset mid-count -> all counters are 0 next cycle.

Source files
------------

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: keeps up to FIFO_DEPTH {pc, instruction} pairs
// ahead of decode, with at most one outstanding word read to memory.
// Optional performance counters are built when INST_PREFETCH_PERF_EN is defined.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   jmp_en, jmp_pc           redirect request and target (bits [1:0] ignored)
//   inst_valid/inst_ready    decode handshake for the head entry
//   inst_code, inst_addr     head instruction and PC
//   mem_read_en, mem_addr    word read request, held until mem_ready
//   mem_rdata, mem_ready     read data and one-cycle response strobe
//   fetch_busy               fetch FSM not idle
//   perf_*_cnt               push / redirect / starved-decode counters (optional)
module inst_prefetch_queue #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0]  BOOT_PC    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jmp_en,
  input  logic [ADDR_WIDTH-1:0] jmp_pc,
  input  logic                  inst_ready,
  output logic                  inst_valid,
  output logic [31:0]           inst_code,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  fetch_busy
`ifdef INST_PREFETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_c, pop_c, credit_ok_c;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [31:0]           fifo_code_q [FIFO_DEPTH];

  // Low target bits are dropped: fetch is word aligned.
  logic unused_jmp_lsbs;
  assign unused_jmp_lsbs = ^jmp_pc[1:0];

  // Head is exposed directly; zero when the queue is empty.
  assign inst_valid  = (count_q != '0);
  assign inst_code   = inst_valid ? fifo_code_q[rd_ptr_q] : 32'h0;
  assign inst_addr   = inst_valid ? fifo_addr_q[rd_ptr_q] : '0;
  assign mem_read_en = (state_q != S_IDLE);
  assign fetch_busy  = (state_q != S_IDLE);
  assign mem_addr    = mem_addr_q;

  // Credit counts the in-flight read so a returning word always has a slot.
  assign credit_ok_c = (count_q + CNT_W'(state_q != S_IDLE)) < CNT_W'(FIFO_DEPTH);
  assign pop_c       = inst_valid && inst_ready && !jmp_en;

  // Fetch FSM, fetch PC and queue bookkeeping.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    push_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!jmp_en && credit_ok_c) begin
          state_d    = S_REQ;
          mem_addr_d = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          state_d = S_IDLE;
          push_c  = !jmp_en;
        end else if (jmp_en) begin
          // Response still owed for the old address; swallow it later.
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (mem_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (jmp_en) begin
      fetch_pc_d = {jmp_pc[ADDR_WIDTH-1:2], 2'b00};
    end else if (push_c) begin
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
    end

    // Flush overrides any push or pop in the same cycle.
    if (jmp_en) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= BOOT_PC;
      mem_addr_q <= BOOT_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_addr_q[wr_ptr_q] <= fetch_pc_q;
      fifo_code_q[wr_ptr_q] <= mem_rdata;
    end
  end

`ifdef INST_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    perf_fetch_d = perf_fetch_q + 32'(push_c);
    perf_flush_d = perf_flush_q + 32'(jmp_en);
    perf_stall_d = perf_stall_q + 32'(!inst_valid && (state_q != S_DISCARD));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: table-driven fill/drain
// vectors, a scoreboard of expected queue entries and request addresses,
// and hand-written redirect / wrap / counter sequences.
module tb_inst_prefetch_queue;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          jmp_en = 1'b0;
  logic [AW-1:0] jmp_pc = '0;
  logic          inst_ready = 1'b0;
  logic          inst_valid;
  logic [31:0]   inst_code;
  logic [AW-1:0] inst_addr;
  logic          mem_read_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          fetch_busy;
`ifdef INST_PREFETCH_PERF_EN
  logic [31:0]   perf_fetch_cnt, perf_flush_cnt, perf_stall_cnt;
  logic [31:0]   w_perf_fetch, w_perf_flush, w_perf_stall;
`endif

  // Second instance booting just below the top of the address space.
  logic          w_inst_valid, w_mem_read_en, w_fetch_busy;
  logic [31:0]   w_inst_code;
  logic [AW-1:0] w_inst_addr, w_mem_addr;

  always #5 clk = ~clk;

  inst_prefetch_queue #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4), .BOOT_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .jmp_en(jmp_en), .jmp_pc(jmp_pc), .inst_ready(inst_ready),
    .inst_valid(inst_valid), .inst_code(inst_code), .inst_addr(inst_addr),
    .mem_read_en(mem_read_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .fetch_busy(fetch_busy)
`ifdef INST_PREFETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  inst_prefetch_queue #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4), .BOOT_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .jmp_en(1'b0), .jmp_pc(32'h0), .inst_ready(1'b0),
    .inst_valid(w_inst_valid), .inst_code(w_inst_code), .inst_addr(w_inst_addr),
    .mem_read_en(w_mem_read_en), .mem_addr(w_mem_addr), .mem_rdata(w_mem_addr),
    .mem_ready(w_mem_read_en), .fetch_busy(w_fetch_busy)
`ifdef INST_PREFETCH_PERF_EN
    , .perf_fetch_cnt(w_perf_fetch), .perf_flush_cnt(w_perf_flush),
    .perf_stall_cnt(w_perf_stall)
`endif
  );

  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  typedef struct {
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ia;
  } vec_t;

  ent_t        exp_q[$];
  vec_t        vt[18];
  int          checks = 0;
  int          errors = 0;
  int          lat = 0;
  int          wait_cnt = 0;
  logic        prev_en = 1'b0;
  logic        discard = 1'b0;
  logic [31:0] exp_pc = '0;
  ent_t        e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic rdy, input logic en, input logic [31:0] addr,
                         input logic valid, input logic [31:0] ia);
    vt[i].rdy = rdy; vt[i].en = en; vt[i].addr = addr; vt[i].valid = valid; vt[i].ia = ia;
  endtask

  // One clock: model the current cycle, advance, then check and drive memory.
  task automatic cycle();
    if (inst_valid && inst_ready && !jmp_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pop_addr", inst_addr, e.a);
      chk("pop_code", inst_code, e.d);
    end
    if (jmp_en) begin
      exp_q.delete();
      exp_pc  = {jmp_pc[31:2], 2'b00};
      discard = mem_read_en && !mem_ready;
    end else if (mem_ready) begin
      if (discard) begin
        discard = 1'b0;
      end else begin
        e.a = exp_pc; e.d = mem_rdata;
        exp_q.push_back(e);
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk); #1;
    if (mem_read_en && !prev_en) chk("req_addr", mem_addr, exp_pc);
    prev_en = mem_read_en;
    chk("head_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
    if (inst_valid && exp_q.size() > 0) chk("head_addr", inst_addr, exp_q[0].a);
    if (mem_read_en) begin
      if (wait_cnt == lat) begin
        mem_ready = 1'b1; mem_rdata = mem_addr ^ 32'hA5A5_0000; wait_cnt = 0;
      end else begin
        mem_ready = 1'b0; wait_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; jmp_en = 1'b0; jmp_pc = '0; inst_ready = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    exp_q.delete(); exp_pc = '0; discard = 1'b0; wait_cnt = 0; prev_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read_en", 32'(mem_read_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_code", inst_code, 32'h0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    // Fill with inst_ready low, then drain for eight cycles (zero-wait memory).
    for (int i = 0; i < 10; i++) begin
      set_vec(i, 1'b0, (i % 2 == 0) && (i < 8), 32'(4 * ((i < 8) ? i / 2 : 3)), i != 0, 32'h0);
    end
    set_vec(10, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h04);
    set_vec(11, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08);
    set_vec(12, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0C);
    set_vec(13, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10);
    set_vec(14, 1'b1, 1'b0, 32'h14, 1'b1, 32'h14);
    set_vec(15, 1'b1, 1'b1, 32'h18, 1'b0, 32'h0);
    set_vec(16, 1'b1, 1'b0, 32'h18, 1'b1, 32'h18);
    set_vec(17, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h0);

    do_reset();
    lat = 0;
    for (int i = 0; i < 18; i++) begin
      inst_ready = vt[i].rdy;
      cycle();
      chk($sformatf("vec%0d_rd_en", i), 32'(mem_read_en), 32'(vt[i].en));
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].addr);
      chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vt[i].valid));
      if (vt[i].valid) begin
        chk($sformatf("vec%0d_ia", i), inst_addr, vt[i].ia);
        chk($sformatf("vec%0d_code", i), inst_code, vt[i].ia ^ 32'hA5A5_0000);
      end
      if (i == 0) chk("wrap_req0", w_mem_addr, 32'hFFFF_FFFC);
      if (i == 2) begin
        chk("wrap_req1_en", 32'(w_mem_read_en), 32'd1);
        chk("wrap_req1", w_mem_addr, 32'h0000_0000);
      end
    end
    inst_ready = 1'b0;

    // Redirect while a slow read is in flight: stale word must be dropped.
    do_reset();
    lat = 3;
    cycle();
    cycle();
    jmp_en = 1'b1; jmp_pc = 32'h0000_0103;
    cycle();
    jmp_en = 1'b0;
    chk("disc_busy", 32'(fetch_busy), 32'd1);
    chk("disc_rd_en", 32'(mem_read_en), 32'd1);
    chk("disc_addr_held", mem_addr, 32'h0);
    for (int n = 0; n < 20 && !(mem_read_en && mem_addr != 32'h0); n++) cycle();
    chk("disc_next_en", 32'(mem_read_en), 32'd1);
    chk("disc_next_addr", mem_addr, 32'h100);
    for (int n = 0; n < 20 && !inst_valid; n++) cycle();
    chk("disc_head_valid", 32'(inst_valid), 32'd1);
    chk("disc_head_addr", inst_addr, 32'h100);

    // Redirect colliding with a response and a pop, two entries queued.
    do_reset();
    lat = 0;
    repeat (5) cycle();
    chk("coll_pre_en", 32'(mem_read_en), 32'd1);
    chk("coll_pre_valid", 32'(inst_valid), 32'd1);
    chk("coll_pre_head", inst_addr, 32'h0);
    jmp_en = 1'b1; jmp_pc = 32'h0000_0200; inst_ready = 1'b1;
    cycle();
    jmp_en = 1'b0; inst_ready = 1'b0;
    chk("coll_valid", 32'(inst_valid), 32'd0);
    chk("coll_rd_en", 32'(mem_read_en), 32'd0);
    cycle();
    chk("coll_req_en", 32'(mem_read_en), 32'd1);
    chk("coll_req_addr", mem_addr, 32'h200);
    repeat (4) cycle();
    chk("coll_head", inst_addr, 32'h200);

`ifdef INST_PREFETCH_PERF_EN
    // Four pushes, two redirects, then reset clears every counter.
    do_reset();
    lat = 0;
    chk("perf_rst_fetch", perf_fetch_cnt, 32'd0);
    repeat (9) cycle();
    chk("perf_fetch4", perf_fetch_cnt, 32'd4);
    jmp_en = 1'b1; jmp_pc = 32'h40;
    cycle();
    jmp_en = 1'b0;
    cycle();
    jmp_en = 1'b1; jmp_pc = 32'h80;
    cycle();
    jmp_en = 1'b0;
    cycle();
    chk("perf_fetch", perf_fetch_cnt, 32'd4);
    chk("perf_flush", perf_flush_cnt, 32'd2);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("perf_clr_fetch", perf_fetch_cnt, 32'd0);
    chk("perf_clr_flush", perf_flush_cnt, 32'd0);
    chk("perf_clr_stall", perf_stall_cnt, 32'd0);
    rst = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
